vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM between two requesters: the VGA display read path and a pixel writer (ADC waveform plotter).
- The display read path is driven by the VGA timing block's request strobe, which leads active video by 2 cycles.
- The display always has priority. Writes are buffered in a small FIFO and retired in cycles where the display is not reading.
- Sits between the VGA timing block, the draw engine and the frame RAM.

---
 rtl/vga_fb_arbiter_if.sv | 14 +
 rtl/vga_fb_arbiter.sv | 122 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer handshake into the frame-buffer arbiter.
// A transfer happens in any cycle where iWr_Valid and oWr_Ready are both high.
interface vga_fb_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 19
);
  logic              iWr_Valid;
  logic [ADDR_W-1:0] iWr_Addr;
  logic [DATA_W-1:0] iWr_Data;
  logic              oWr_Ready;

  modport master (output iWr_Valid, iWr_Addr, iWr_Data, input oWr_Ready);
  modport slave  (input iWr_Valid, iWr_Addr, iWr_Data, output oWr_Ready);
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port frame RAM between the VGA display reader and a pixel writer.
// The display always wins; writes are queued in a small FIFO and retired in idle cycles.
module vga_fb_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iRequest,
  input  logic                          iFrame_Start,
  output logic [DATA_W-1:0]             oPixel,
  output logic                          oPixel_Valid,
  vga_fb_arbiter_if.slave               wr,
  output logic [ADDR_W-1:0]             oMem_Addr,
  output logic [DATA_W-1:0]             oMem_WData,
  output logic                          oMem_WE,
  input  logic [DATA_W-1:0]             iMem_RData,
  output logic [$clog2(FIFO_DEPTH):0]   oFifo_Level,
  output logic [1:0]                    oErr
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACT * V_ACT - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] rdAddr;
  logic [ADDR_W-1:0] reqAddr;
  logic              wrapped;
  logic              reqD1;

  logic [ADDR_W-1:0] fifoAddr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  nextLevel;
  logic              ready;
  logic              push;
  logic              pop;
  logic              headBad;

  assign reqAddr     = iFrame_Start ? '0 : rdAddr;
  assign push        = wr.iWr_Valid && ready;
  assign pop         = !iRequest && (level != '0);
  assign headBad     = fifoAddr[rdPtr] > LAST_ADDR;
  assign wr.oWr_Ready = ready;
  assign oFifo_Level = level;

  always_comb begin
    oMem_Addr  = '0;
    oMem_WData = '0;
    oMem_WE    = 1'b0;
    if (iRequest) begin
      oMem_Addr = reqAddr;
    end else if (pop) begin
      oMem_Addr  = fifoAddr[rdPtr];
      oMem_WData = fifoData[rdPtr];
      oMem_WE    = !headBad;
    end
  end

  always_comb begin
    nextLevel = level;
    if (push && !pop)      nextLevel = level + 1'b1;
    else if (pop && !push) nextLevel = level - 1'b1;
  end

  // wrapped marks a counter wrap with no frame start since; a read at 0 then is an overrun
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rdAddr       <= '0;
      wrapped      <= 1'b0;
      reqD1        <= 1'b0;
      oPixel       <= '0;
      oPixel_Valid <= 1'b0;
      oErr         <= '0;
    end else begin
      reqD1        <= iRequest;
      oPixel_Valid <= reqD1;
      if (reqD1) oPixel <= iMem_RData;
      if (iRequest) begin
        if (!iFrame_Start && wrapped && rdAddr == '0) oErr[0] <= 1'b1;
        if (reqAddr == LAST_ADDR) begin
          rdAddr  <= '0;
          wrapped <= 1'b1;
        end else begin
          rdAddr <= reqAddr + 1'b1;
          if (iFrame_Start) wrapped <= 1'b0;
        end
      end else if (iFrame_Start) begin
        rdAddr  <= '0;
        wrapped <= 1'b0;
      end
      if (pop && headBad) oErr[1] <= 1'b1;
    end
  end

  // ready is registered from the next level so iWr_Valid never reaches oWr_Ready combinationally
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      ready <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      level <= nextLevel;
      ready <= nextLevel < FULL_LVL;
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) begin
      fifoAddr[wrPtr] <= wr.iWr_Addr;
      fifoData[wrPtr] <= wr.iWr_Data;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter using a reduced frame size.
// The RAM model returns address[7:0] one cycle after the address is presented.
module tb_vga_fb_arbiter;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 19;
  localparam int unsigned HA    = 40;
  localparam int unsigned VA    = 8;
  localparam int unsigned FD    = 4;
  localparam int unsigned FRAME = HA * VA;

  typedef struct { logic [7:0] d; int unsigned c; } pix_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wrq_t;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iRequest = 1'b0;
  logic          iFrame_Start = 1'b0;
  logic [DW-1:0] oPixel;
  logic          oPixel_Valid;
  logic [AW-1:0] oMem_Addr;
  logic [DW-1:0] oMem_WData;
  logic          oMem_WE;
  logic [DW-1:0] iMem_RData = '0;
  logic [$clog2(FD):0] oFifo_Level;
  logic [1:0]    oErr;

  pix_t pixQ[$];
  wrq_t wrQ[$];
  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned cyc = 0;
  int unsigned modelRd = 0;
  logic [AW-1:0] expReqAddr = '0;
  logic monOn = 1'b0;
  logic lastWe;
  logic lastRdy;
  logic [$clog2(FD):0] lastLvl;

  vga_fb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) wr ();

  vga_fb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .H_ACT(HA), .V_ACT(VA), .FIFO_DEPTH(FD)) dut (
    .iCLK(iCLK), .iRST(iRST), .iRequest(iRequest), .iFrame_Start(iFrame_Start),
    .oPixel(oPixel), .oPixel_Valid(oPixel_Valid), .wr(wr),
    .oMem_Addr(oMem_Addr), .oMem_WData(oMem_WData), .oMem_WE(oMem_WE),
    .iMem_RData(iMem_RData), .oFifo_Level(oFifo_Level), .oErr(oErr)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    cyc        <= cyc + 1;
    iMem_RData <= oMem_Addr[7:0];
  end

  always @(negedge iCLK) begin : monitor
    pix_t ep;
    wrq_t ew;
    if (monOn) begin
      if (iRequest) begin
        compared++;
        if (oMem_Addr !== expReqAddr || oMem_WE !== 1'b0) begin
          mismatched++;
          $display("FAIL rd_addr: got addr %0d we %b, expected addr %0d we 0", oMem_Addr, oMem_WE, expReqAddr);
        end
      end
      if (oPixel_Valid === 1'b1) begin
        compared++;
        if (pixQ.size() == 0) begin
          mismatched++;
          $display("FAIL pixel_extra: got pixel %h at cycle %0d, expected none", oPixel, cyc);
        end else begin
          ep = pixQ.pop_front();
          if (oPixel !== ep.d || cyc != ep.c) begin
            mismatched++;
            $display("FAIL pixel: got %h at cycle %0d, expected %h at cycle %0d", oPixel, cyc, ep.d, ep.c);
          end
        end
      end
      if (oMem_WE === 1'b1) begin
        compared++;
        if (wrQ.size() == 0) begin
          mismatched++;
          $display("FAIL write_extra: got addr %0d data %h, expected no write", oMem_Addr, oMem_WData);
        end else begin
          ew = wrQ.pop_front();
          if (oMem_Addr !== ew.a || oMem_WData !== ew.d) begin
            mismatched++;
            $display("FAIL write: got addr %0d data %h, expected addr %0d data %h", oMem_Addr, oMem_WData, ew.a, ew.d);
          end
        end
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic req, input logic fs, input logic wv,
                      input int unsigned a, input int unsigned d, output logic acc);
    int unsigned t;
    iRequest     = req;
    iFrame_Start = fs;
    wr.iWr_Valid = wv;
    wr.iWr_Addr  = AW'(a);
    wr.iWr_Data  = DW'(d);
    acc = wv && (wr.oWr_Ready === 1'b1);
    if (acc && a < FRAME) wrQ.push_back('{AW'(a), DW'(d)});
    if (req) begin
      expReqAddr = fs ? '0 : AW'(modelRd);
      pixQ.push_back('{expReqAddr[7:0], cyc + 2});
      t = int'(expReqAddr);
      modelRd = (t + 1) % FRAME;
    end else if (fs) begin
      modelRd = 0;
    end
    #1;
    lastWe  = oMem_WE;
    lastRdy = wr.oWr_Ready;
    lastLvl = oFifo_Level;
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    logic acc;
    for (int i = 0; i < int'(n); i++) step(1'b0, 1'b0, 1'b0, 0, 0, acc);
  endtask

  task automatic check_drained(input string name);
    compared++;
    if (pixQ.size() != 0 || wrQ.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: got %0d pixels %0d writes pending, expected 0 and 0", name, pixQ.size(), wrQ.size());
    end
  endtask

  task automatic test_reset;
    iRST = 1'b1;
    wr.iWr_Valid = 1'b0; wr.iWr_Addr = '0; wr.iWr_Data = '0;
    @(posedge iCLK); #2;
    compared++;
    if ({oPixel, oPixel_Valid, wr.oWr_Ready, oFifo_Level, oErr, oMem_WE} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got pix %h v %b rdy %b lvl %0d err %b we %b, expected all 0",
               oPixel, oPixel_Valid, wr.oWr_Ready, oFifo_Level, oErr, oMem_WE);
    end
    @(negedge iCLK); iRST = 1'b0;
    @(posedge iCLK); #1;
    compared++;
    if (wr.oWr_Ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b, expected 1", wr.oWr_Ready);
    end
    monOn = 1'b1;
  endtask

  task automatic test_frame_read;
    logic acc;
    step(1'b1, 1'b1, 1'b0, 0, 0, acc);
    for (int i = 1; i < 300; i++) step(1'b1, 1'b0, 1'b0, 0, 0, acc);
    idle(4);
    check_drained("frame_read");
  endtask

  task automatic test_writes;
    logic acc;
    logic [5:0] weSeen;
    int unsigned peak;
    int unsigned nAcc;
    int unsigned addrs[3] = '{5, 6, 7};
    int unsigned datas[3] = '{8'hA5, 8'h5A, 8'hFF};
    weSeen = '0; peak = 0; nAcc = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) step(1'b0, 1'b0, 1'b1, addrs[i], datas[i], acc);
      else       step(1'b0, 1'b0, 1'b0, 0, 0, acc);
      if (acc) nAcc++;
      if (i < 6) weSeen[i] = lastWe;
      if (int'(lastLvl) > int'(peak)) peak = int'(lastLvl);
    end
    compared++;
    if (nAcc != 3) begin mismatched++; $display("FAIL wr_accept: got %0d, expected 3", nAcc); end
    compared++;
    if (weSeen !== 6'b001110) begin mismatched++; $display("FAIL wr_timing: got %b, expected 001110", weSeen); end
    compared++;
    if (peak != 1) begin mismatched++; $display("FAIL wr_peak: got %0d, expected 1", peak); end
    compared++;
    if (lastLvl !== '0) begin mismatched++; $display("FAIL wr_level_end: got %0d, expected 0", lastLvl); end
    check_drained("writes");
  endtask

  task automatic test_back_to_back;
    logic acc;
    int unsigned nAcc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 100 + i, 8'h10 + i, acc);
      if (acc) nAcc++;
    end
    compared++;
    if (lastRdy !== 1'b0 || lastLvl !== 3'd4) begin
      mismatched++;
      $display("FAIL b2b_full: got rdy %b lvl %0d, expected rdy 0 lvl 4", lastRdy, lastLvl);
    end
    compared++;
    if (nAcc != 4) begin mismatched++; $display("FAIL b2b_accept: got %0d, expected 4", nAcc); end
    idle(8);
    compared++;
    if (lastRdy !== 1'b1 || lastLvl !== '0) begin
      mismatched++;
      $display("FAIL b2b_drain: got rdy %b lvl %0d, expected rdy 1 lvl 0", lastRdy, lastLvl);
    end
    check_drained("b2b");
  endtask

  task automatic test_illegal;
    logic acc;
    step(1'b0, 1'b0, 1'b1, FRAME, 8'h33, acc);
    idle(4);
    compared++;
    if (lastLvl !== '0 || oErr !== 2'b10) begin
      mismatched++;
      $display("FAIL illegal_addr: got lvl %0d err %b, expected lvl 0 err 10", lastLvl, oErr);
    end
    check_drained("illegal");
  endtask

  task automatic test_overrun;
    logic acc;
    step(1'b0, 1'b1, 1'b0, 0, 0, acc);
    for (int i = 0; i < int'(FRAME); i++) step(1'b1, 1'b0, 1'b0, 0, 0, acc);
    compared++;
    if (oErr !== 2'b10) begin mismatched++; $display("FAIL overrun_early: got %b, expected 10", oErr); end
    step(1'b1, 1'b0, 1'b0, 0, 0, acc);
    compared++;
    if (oErr !== 2'b11) begin mismatched++; $display("FAIL overrun_set: got %b, expected 11", oErr); end
    step(1'b0, 1'b1, 1'b0, 0, 0, acc);
    idle(3);
    compared++;
    if (oErr !== 2'b11) begin mismatched++; $display("FAIL overrun_sticky: got %b, expected 11", oErr); end
    check_drained("overrun");
  endtask

  task automatic test_reset_mid;
    logic acc;
    step(1'b1, 1'b0, 1'b1, 200, 8'h77, acc);
    step(1'b1, 1'b0, 1'b1, 201, 8'h78, acc);
    step(1'b1, 1'b0, 1'b0, 0, 0, acc);
    compared++;
    if (oFifo_Level !== 3'd2) begin mismatched++; $display("FAIL mid_level: got %0d, expected 2", oFifo_Level); end
    #2;
    monOn = 1'b0;
    iRST = 1'b1;
    iRequest = 1'b0; iFrame_Start = 1'b0; wr.iWr_Valid = 1'b0;
    #1;
    compared++;
    if ({oPixel, oPixel_Valid, wr.oWr_Ready, oFifo_Level, oErr, oMem_WE} !== '0) begin
      mismatched++;
      $display("FAIL mid_reset: got pix %h v %b rdy %b lvl %0d err %b we %b, expected all 0",
               oPixel, oPixel_Valid, wr.oWr_Ready, oFifo_Level, oErr, oMem_WE);
    end
    pixQ.delete();
    wrQ.delete();
    modelRd = 0;
    @(negedge iCLK); iRST = 1'b0;
    @(posedge iCLK); #1;
    compared++;
    if (wr.oWr_Ready !== 1'b1) begin mismatched++; $display("FAIL mid_ready: got %b, expected 1", wr.oWr_Ready); end
    monOn = 1'b1;
    step(1'b1, 1'b0, 1'b0, 0, 0, acc);
    idle(3);
    compared++;
    if (oErr !== 2'b00) begin mismatched++; $display("FAIL mid_err: got %b, expected 00", oErr); end
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_frame_read();
    test_writes();
    test_back_to_back();
    test_illegal();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000");
    $fatal(1);
  end
endmodule
